// File: rtl/ps2_kbd_event_fifo_pkg.sv
// Shared constants, event layout and receiver state encoding for the PS/2
// keyboard event FIFO.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  localparam int EV_EXT     = 9;
  localparam int EV_BRK     = 8;
  localparam int EV_CODE_HI = 7;
  localparam int EV_CODE_LO = 0;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_e;

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_kbd_event_fifo_if.sv
// CPU-side keyboard port: read strobe, head entry, occupancy and sticky flags.
// io_rdn low together with ready high at a sys_clk edge is exactly one pop;
// key_data is meaningful only while ready is high and reads 0 otherwise.
interface ps2_kbd_event_fifo_if
  import ps2_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) ();

  logic                  io_rdn;
  logic                  ovf_clr;
  logic [9:0]            key_data;
  logic                  ready;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  parity_err;
  rx_state_e             rx_state;

  modport slave (
    input  io_rdn, ovf_clr,
    output key_data, ready, count, overflow, parity_err, rx_state
  );

  modport master (
    output io_rdn, ovf_clr,
    input  key_data, ready, count, overflow, parity_err, rx_state
  );

endinterface

// File: rtl/ps2_kbd_event_fifo_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronizers, falling-edge detect,
// IDLE/RECV framing with odd-parity/stop check and a stall timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic       sys_clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output rx_state_e  state
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0] STOP_BIT = 4'(PS2_FRAME_BITS - 1);

  logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic fall_q, fall_d, fall_dat_q, fall_dat_d;
  rx_state_e state_q, state_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          valid_q, valid_d, err_q, err_d;

  always_ff @(posedge sys_clk) begin
    if (clr) begin
      clk_s1_q   <= 1'b0;
      clk_s2_q   <= 1'b0;
      clk_prev_q <= 1'b0;
      dat_s1_q   <= 1'b0;
      dat_s2_q   <= 1'b0;
      fall_q     <= 1'b0;
      fall_dat_q <= 1'b0;
      state_q    <= RX_IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_prev_q <= clk_prev_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      fall_q     <= fall_d;
      fall_dat_q <= fall_dat_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // Data is sampled alongside the fall pulse so both arrive at the FSM together.
  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    fall_d     = clk_prev_q & ~clk_s2_q;
    fall_dat_d = dat_s2_q;
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    tmo_d    = tmo_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        tmo_d = '0;
        if (fall_q && !fall_dat_q) begin
          state_d  = RX_RECV;
          bitcnt_d = 4'd1;
        end
      end
      RX_RECV: begin
        if (fall_q) begin
          tmo_d    = '0;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q <= 4'd8) begin
            shreg_d = {fall_dat_q, shreg_q[7:1]};
          end else if (bitcnt_q < STOP_BIT) begin
            par_d = fall_dat_q;
          end else begin
            state_d  = RX_IDLE;
            bitcnt_d = '0;
            if (fall_dat_q && odd_parity_ok(shreg_q, par_q)) valid_d = 1'b1;
            else                                              err_d   = 1'b1;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d  = RX_IDLE;
          bitcnt_d = '0;
          tmo_d    = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = valid_q;
    frame_err  = err_q;
    rx_byte    = shreg_q;
    state      = state_q;
  end

endmodule

// File: rtl/ps2_kbd_event_fifo.sv
// PS/2 keyboard front end: frame receiver, optional E0/F0 prefix folding and a
// circular event FIFO drained by the CPU through the keyboard port.
module ps2_kbd_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int TIMEOUT    = 50000,
  parameter int DECODE     = 1
) (
  input  logic                 sys_clk,
  input  logic                 clr,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  ps2_kbd_event_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic       byte_valid, frame_err;
  logic [7:0] rx_byte;
  rx_state_e  rx_state;

  ps2_frame_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .sys_clk    (sys_clk),
    .clr        (clr),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err),
    .state      (rx_state)
  );

  logic                  ext_q, ext_d, brk_q, brk_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ready_q, ready_d, ovf_q, ovf_d, perr_q, perr_d;
  logic [9:0]            mem_q [DEPTH];
  logic [9:0]            mem_d [DEPTH];
  logic                  push, pop, full, do_push, drop;
  logic [9:0]            ev;

  always_ff @(posedge sys_clk) begin
    if (clr) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
    end
  end

  // Storage needs no reset: key_data is forced to 0 whenever the FIFO is empty.
  always_ff @(posedge sys_clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    push  = 1'b0;
    ev    = '0;
    if (byte_valid) begin
      if (DECODE != 0 && rx_byte == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (DECODE != 0 && rx_byte == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        push                       = 1'b1;
        ev[EV_EXT]                 = (DECODE != 0) ? ext_q : 1'b0;
        ev[EV_BRK]                 = (DECODE != 0) ? brk_q : 1'b0;
        ev[EV_CODE_HI:EV_CODE_LO]  = rx_byte;
        ext_d                      = 1'b0;
        brk_d                      = 1'b0;
      end
    end
  end

  // When full, wr_ptr equals rd_ptr, so a simultaneous push reuses the slot being popped.
  always_comb begin
    pop      = ~bus.io_rdn & ready_q;
    full     = (count_q == CW'(DEPTH));
    do_push  = push & (~full | pop);
    drop     = push & full & ~pop;
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = ev;
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(do_push);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
    count_d  = count_q + CW'(do_push) - CW'(pop);
    ready_d  = (count_d != '0);
    ovf_d    = (ovf_q & ~bus.ovf_clr) | drop;
    perr_d   = (perr_q & ~bus.ovf_clr) | frame_err;
  end

  always_comb begin
    bus.key_data   = ready_q ? mem_q[rd_ptr_q] : 10'h000;
    bus.ready      = ready_q;
    bus.count      = count_q;
    bus.overflow   = ovf_q;
    bus.parity_err = perr_q;
    bus.rx_state   = rx_state;
  end

endmodule

// File: tb/tb_ps2_kbd_event_fifo.sv
// Directed bench for ps2_kbd_event_fifo: a 4-deep decoding instance and an
// 8-deep raw instance share the PS/2 pins and are checked against queue models.
module tb_ps2_kbd_event_fifo;
  import ps2_pkg::*;

  localparam int TMO = 200;

  logic sys_clk = 1'b0;
  logic clr     = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];
  logic ext_m = 1'b0, brk_m = 1'b0;
  logic eovf_a = 1'b0, epe_a = 1'b0, eovf_b = 1'b0, epe_b = 1'b0;

  ps2_kbd_event_fifo_if #(.DEPTH_LOG2(2)) ifa ();
  ps2_kbd_event_fifo_if #(.DEPTH_LOG2(3)) ifb ();

  ps2_kbd_event_fifo #(.DEPTH_LOG2(2), .TIMEOUT(TMO), .DECODE(1)) dut_a (
    .sys_clk (sys_clk), .clr (clr), .ps2_clk (ps2_clk), .ps2_data (ps2_data), .bus (ifa)
  );

  ps2_kbd_event_fifo #(.DEPTH_LOG2(3), .TIMEOUT(TMO), .DECODE(0)) dut_b (
    .sys_clk (sys_clk), .clr (clr), .ps2_clk (ps2_clk), .ps2_data (ps2_data), .bus (ifb)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".a.count"}, 32'(ifa.count), 32'(exp_a.size()));
    chk({tag, ".a.ready"}, 32'(ifa.ready), 32'(exp_a.size() != 0));
    chk({tag, ".a.key"}, 32'(ifa.key_data), (exp_a.size() != 0) ? 32'(exp_a[0]) : 32'h0);
    chk({tag, ".a.ovf"}, 32'(ifa.overflow), 32'(eovf_a));
    chk({tag, ".a.perr"}, 32'(ifa.parity_err), 32'(epe_a));
    chk({tag, ".b.count"}, 32'(ifb.count), 32'(exp_b.size()));
    chk({tag, ".b.key"}, 32'(ifb.key_data), (exp_b.size() != 0) ? 32'(exp_b[0]) : 32'h0);
    chk({tag, ".b.ovf"}, 32'(ifb.overflow), 32'(eovf_b));
    chk({tag, ".b.perr"}, 32'(ifb.parity_err), 32'(epe_b));
  endtask

  // Reference behaviour of both instances once a whole frame has been received.
  task automatic model_frame(input logic [7:0] b, input bit bad, input bit pop_a);
    if (pop_a && exp_a.size() != 0) void'(exp_a.pop_front());
    if (bad) begin
      epe_a = 1'b1;
      epe_b = 1'b1;
    end else begin
      if (b == 8'hE0) ext_m = 1'b1;
      else if (b == 8'hF0) brk_m = 1'b1;
      else begin
        if (exp_a.size() < 4) exp_a.push_back({ext_m, brk_m, b});
        else eovf_a = 1'b1;
        ext_m = 1'b0;
        brk_m = 1'b0;
      end
      if (exp_b.size() < 8) exp_b.push_back({2'b00, b});
      else eovf_b = 1'b1;
    end
  endtask

  // Drives the first nbits of a frame; the stop-bit fall optionally checks
  // latency and/or pops instance A on the push edge.
  task automatic send_bits(input logic [7:0] b, input bit bad, input int nbits,
                           input bit lat_chk, input bit pop_a);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      tick(1);
      ps2_data = bits[i];
      tick(3);
      ps2_clk = 1'b0;
      if (i == 10) begin
        tick(4);
        if (lat_chk) chk("lat4.ready", 32'(ifa.ready), 32'h0);
        if (pop_a) begin
          chk("pp.head", 32'(ifa.key_data), 32'(exp_a[0]));
          ifa.io_rdn = 1'b0;
        end
        tick(1);
        ifa.io_rdn = 1'b1;
        if (lat_chk) begin
          chk("lat5.ready", 32'(ifa.ready), 32'h1);
          chk("lat5.key", 32'(ifa.key_data), 32'h01C);
          chk("lat5.count", 32'(ifa.count), 32'h1);
        end
        tick(3);
      end else begin
        tick(8);
      end
      ps2_clk = 1'b1;
      tick(4);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    send_bits(b, bad, 11, 1'b0, 1'b0);
    model_frame(b, bad, 1'b0);
  endtask

  task automatic pop_a();
    chk("pop.a.ready", 32'(ifa.ready), 32'h1);
    chk("pop.a.key", 32'(ifa.key_data), 32'(exp_a[0]));
    ifa.io_rdn = 1'b0;
    tick(1);
    ifa.io_rdn = 1'b1;
    void'(exp_a.pop_front());
  endtask

  task automatic pop_b();
    chk("pop.b.ready", 32'(ifb.ready), 32'h1);
    chk("pop.b.key", 32'(ifb.key_data), 32'(exp_b[0]));
    ifb.io_rdn = 1'b0;
    tick(1);
    ifb.io_rdn = 1'b1;
    void'(exp_b.pop_front());
  endtask

  task automatic drain(input string tag);
    while (exp_a.size() != 0) pop_a();
    while (exp_b.size() != 0) pop_b();
    chk_all(tag);
  endtask

  task automatic pulse_ovf_clr();
    ifa.ovf_clr = 1'b1;
    ifb.ovf_clr = 1'b1;
    tick(1);
    ifa.ovf_clr = 1'b0;
    ifb.ovf_clr = 1'b0;
    eovf_a = 1'b0; epe_a = 1'b0; eovf_b = 1'b0; epe_b = 1'b0;
  endtask

  initial begin
    ifa.io_rdn = 1'b1; ifa.ovf_clr = 1'b0;
    ifb.io_rdn = 1'b1; ifb.ovf_clr = 1'b0;
    tick(3);
    clr = 1'b0;
    tick(3);
    chk_all("reset");
    chk("reset.a.state", 32'(ifa.rx_state), 32'(RX_IDLE));

    // Single make code with latency measured from the stop-bit fall.
    send_bits(8'h1C, 1'b0, 11, 1'b1, 1'b0);
    model_frame(8'h1C, 1'b0, 1'b0);
    chk_all("one");
    drain("one.drain");

    // Break and extended-break prefixes.
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk_all("prefix");
    drain("prefix.drain");

    // Bad parity, then recovery and sticky clear.
    send_frame(8'h1C, 1'b1);
    chk_all("badpar");
    send_frame(8'h29, 1'b0);
    chk_all("after_bad");
    drain("after_bad.drain");
    pulse_ovf_clr();
    chk_all("perr_clr");

    // Overflow of the 4-deep instance, then push+pop while full.
    send_frame(8'h15, 1'b0);
    send_frame(8'h1D, 1'b0);
    send_frame(8'h24, 1'b0);
    send_frame(8'h2D, 1'b0);
    send_frame(8'h2C, 1'b0);
    chk_all("ovf");
    pulse_ovf_clr();
    chk_all("ovf_clr");
    send_bits(8'h33, 1'b0, 11, 1'b0, 1'b1);
    model_frame(8'h33, 1'b0, 1'b1);
    chk_all("pushpop_full");
    drain("ovf.drain");

    // Stalled partial frame is discarded silently.
    send_bits(8'h5A, 1'b0, 5, 1'b0, 1'b0);
    tick(TMO + 10);
    chk_all("timeout");
    send_frame(8'h29, 1'b0);
    chk_all("after_tmo");
    drain("tmo.drain");

    // Raw mode keeps prefix bytes as entries.
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk_all("raw");
    drain("raw.drain");

    // clr mid-frame with content, a sticky flag and a pending prefix.
    send_frame(8'h15, 1'b0);
    send_frame(8'h1C, 1'b1);
    send_frame(8'hE0, 1'b0);
    send_bits(8'h66, 1'b0, 4, 1'b0, 1'b0);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    exp_a.delete();
    exp_b.delete();
    ext_m = 1'b0; brk_m = 1'b0;
    eovf_a = 1'b0; epe_a = 1'b0; eovf_b = 1'b0; epe_b = 1'b0;
    chk_all("clr");
    tick(4);
    send_frame(8'h1C, 1'b0);
    chk_all("after_clr");
    drain("clr.drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
